// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state, constants and helpers for the boot loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CKSUM,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  typedef logic [1:0] lane_t;

  // States in which the inter-byte timeout is armed
  function automatic logic is_active(input state_e s);
    return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CKSUM);
  endfunction

endpackage

// File: rtl/prog_loader_packer.sv
// rtl/prog_loader_packer.sv - little-endian byte to 32-bit word assembly with lane counter
module prog_loader_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic        word_valid,
  output logic [31:0] word_data
);

  lane_t       lane_q, lane_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  assign word_done  = byte_en && (lane_q == 2'd3);
  assign word_valid = word_valid_q;
  assign word_data  = word_q;

  always_comb begin
    lane_d       = lane_q;
    asm_d        = asm_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clr) begin
      lane_d = '0;
    end else if (byte_en) begin
      lane_d = lane_q + 2'd1;
      // The output word is only replaced on the last lane so it stays stable during the strobe
      if (lane_q == 2'd3) begin
        word_d       = {byte_data, asm_q};
        word_valid_d = 1'b1;
      end else begin
        asm_d[{lane_q, 3'b000} +: 8] = byte_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q       <= '0;
      asm_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream program loader writing imem and gating CPU reset
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int          TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;
`ifdef PROG_LOADER_CKSUM_EN
  localparam state_e      LAST_ST   = CKSUM;
`else
  localparam state_e      LAST_ST   = DONE;
`endif

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  logic        accept;
  logic        frame_start;
  logic        byte_en;
  logic        word_done;
  logic        timeout;
  logic [15:0] len_n;

  assign accept      = in_valid && in_ready_q;
  assign frame_start = accept && (in_data == LOADER_MAGIC) &&
                       ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign byte_en     = accept && (state_q == DATA);
  assign timeout     = !accept && is_active(state_q) && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign len_n       = {in_data, len_q[7:0]};

  prog_loader_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (frame_start),
    .byte_en    (byte_en),
    .byte_data  (in_data),
    .word_done  (word_done),
    .word_valid (imem_we),
    .word_data  (imem_wdata)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    imem_addr_d = imem_addr_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
`ifdef PROG_LOADER_CKSUM_EN
    cksum_d     = cksum_q;
`endif

    if (accept || timeout) begin
      tmo_d = '0;
    end else if (is_active(state_q)) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      IDLE, DONE, ERR: begin
        if (frame_start) begin
          state_d    = LEN0;
          cpu_rst_d  = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          word_idx_d = '0;
`ifdef PROG_LOADER_CKSUM_EN
          cksum_d    = '0;
`endif
        end
      end
      LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d = len_n;
          if (len_n == 16'd0) begin
            state_d = LAST_ST;
          end else if ({17'd0, len_n} > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
`ifdef PROG_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ in_data;
`endif
          // Address is registered alongside the packer's write strobe
          if (word_done) begin
            imem_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx_q);
            word_idx_d  = word_idx_q + 16'd1;
            if (word_idx_q == len_q - 16'd1) begin
              state_d = LAST_ST;
            end
          end
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      CKSUM: begin
        if (accept) begin
          state_d = (in_data == cksum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = ERR;
    end

    if ((state_d == DONE) && (state_q != DONE)) begin
      done_d    = 1'b1;
      cpu_rst_d = 1'b0;
    end
    if ((state_d == ERR) && (state_q != ERR)) begin
      err_d     = 1'b1;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      len_q       <= '0;
      word_idx_q  <= '0;
      imem_addr_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= 1'b1;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      imem_addr_q <= imem_addr_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign imem_addr = imem_addr_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader (honours PROG_LOADER_CKSUM_EN)
module tb_prog_loader;

  localparam int ADDR_W = 4;
  localparam int TMO    = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] byte_q[$];

  prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every imem write must match the oldest expected write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e.addr));
          check("write_data", imem_wdata, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_body(input logic [7:0] ck);
    foreach (byte_q[i]) send_byte(byte_q[i]);
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(ck);
`else
    if (ck === 8'hxx) $display("unused checksum");
`endif
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic c);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(c));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // 1: two-word image
    exp_q.push_back('{addr: 4'd0, data: 32'h44332211});
    exp_q.push_back('{addr: 4'd1, data: 32'h88776655});
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_header(16'd2);
    send_body(8'h88);
    check_status("t1", 1'b1, 1'b0, 1'b0);
    drain();

`ifdef PROG_LOADER_CKSUM_EN
    // 2: bad checksum, writes already issued remain
    exp_q.push_back('{addr: 4'd0, data: 32'h44332211});
    exp_q.push_back('{addr: 4'd1, data: 32'h88776655});
    send_header(16'd2);
    send_body(8'h00);
    check_status("t2", 1'b0, 1'b1, 1'b1);
    drain();
`endif

    // 3: empty image, then reload
    byte_q = {};
    send_header(16'd0);
    send_body(8'h00);
    check_status("t3_empty", 1'b1, 1'b0, 1'b0);
    drain();
    send_byte(8'hA5);
    check_status("t3_restart", 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{addr: 4'd0, data: 32'hEFBEADDE});
    send_byte(8'h01);
    send_byte(8'h00);
    byte_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_body(8'h22);
    check_status("t3_reload", 1'b1, 1'b0, 1'b0);
    drain();

    // 4: stall mid-word until the timeout fires
    send_header(16'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("t4_err_before_timeout", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    check_status("t4_timeout", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5);
    check("t4_err_cleared", 32'(err), 32'd0);
    byte_q = {};
    send_byte(8'h00);
    send_byte(8'h00);
    send_body(8'h00);
    check_status("t4_recover", 1'b1, 1'b0, 1'b0);
    drain();

    // 5: garbage dropped, oversize length rejected, full-size image accepted
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'hFF);
    check_status("t5_garbage", 1'b1, 1'b0, 1'b0);
    send_header(16'h0011);
    check_status("t5_too_long", 1'b0, 1'b1, 1'b1);
    drain();
    byte_q = {};
    for (int w = 0; w < 16; w++) begin
      exp_q.push_back('{addr: 4'(w),
                        data: {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}});
      for (int k = 0; k < 4; k++) byte_q.push_back(8'(4*w+k));
    end
    send_header(16'd16);
    send_body(8'h00);
    check_status("t5_full", 1'b1, 1'b0, 1'b0);
    drain();

    // 6: asynchronous reset in the middle of DATA
    exp_q.push_back('{addr: 4'd0, data: 32'h44332211});
    send_header(16'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6_pending", 32'(exp_q.size()), 32'd0);
    send_byte(8'h00);
    send_byte(8'h5A);
    check_status("t6_idle_garbage", 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{addr: 4'd0, data: 32'h44332211});
    exp_q.push_back('{addr: 4'd1, data: 32'h88776655});
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_header(16'd2);
    send_body(8'h88);
    check_status("t6_reload", 1'b1, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
